// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data width, access width encoding,
// the latched request payload and access-geometry helpers.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE     = 2'd0,
        WIDTH_HALFWORD = 2'd1,
        WIDTH_WORD     = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic            is_store;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] w_data;
        mem_width_t      width;
        logic            is_unsigned;
    } lsu_req_t;

    function automatic logic [2:0] width_bytes(input mem_width_t width);
        case (width)
            WIDTH_BYTE:     return 3'd1;
            WIDTH_HALFWORD: return 3'd2;
            default:        return 3'd4;
        endcase
    endfunction

    // True when an access starting at this byte offset spills into the next word.
    function automatic logic crosses_word(input logic [1:0] offset, input mem_width_t width);
        return ({1'b0, offset} + width_bytes(width)) > 3'd4;
    endfunction

endpackage

// File: rtl/load_store_unit_load_aligner.sv
// Combinational load-data path: merges the two halves of a split load,
// truncates to the access width and sign/zero extends.
module load_aligner
    import load_store_unit_pkg::*;
(
    input  mem_width_t      width,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    input  logic            split,
    input  logic [XLEN-1:0] low,
    input  logic [XLEN-1:0] high,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] merged;
    logic [5:0]      high_shift;

    always_comb begin
        high_shift = 6'(XLEN) - {1'b0, offset, 3'b000};
        merged     = high;
        // Low read holds bytes offset..3 right-aligned; the second read fills above them.
        if (split) begin
            merged = (low & ({XLEN{1'b1}} >> {offset, 3'b000})) | (high << high_shift);
        end
        case (width)
            WIDTH_BYTE:     data = {{(XLEN-8){merged[7] & ~is_unsigned}}, merged[7:0]};
            WIDTH_HALFWORD: data = {{(XLEN-16){merged[15] & ~is_unsigned}}, merged[15:0]};
            default:        data = merged;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a byte-enabled data RAM. Word-crossing accesses are
// split into legal RAM accesses when LSU_MISALIGNED_EN is defined, else rejected.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_w_data,
    input  mem_width_t      req_width,
    input  logic            req_unsigned,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_r_data,
    output logic            resp_misaligned,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    output mem_width_t      mem_w_width,
    output logic            mem_w_enable,
    input  logic [XLEN-1:0] mem_r_data
);

`ifdef LSU_MISALIGNED_EN
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DONE        = 2'd1,
        LOAD_SPLIT  = 2'd2,
        STORE_SPLIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
    } state_t;
`endif

    state_t          state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic            cross_in;
    logic            split;
    logic [XLEN-1:0] low_part;
    logic [XLEN-1:0] load_data;

`ifdef LSU_MISALIGNED_EN
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] low_q, low_d;

    assign split           = crosses_word(req_q.addr[1:0], req_q.width);
    assign low_part        = low_q;
    assign resp_misaligned = 1'b0;
`else
    logic mis_q, mis_d;
    logic unused_req;

    assign split           = 1'b0;
    assign low_part        = '0;
    assign resp_misaligned = !reset && (state_q == DONE) && mis_q;
    assign unused_req      = ^{req_q.addr[XLEN-1:2], req_q.w_data};
`endif

    assign cross_in = crosses_word(req_addr[1:0], req_width);

    load_aligner u_load_aligner (
        .width       (req_q.width),
        .is_unsigned (req_q.is_unsigned),
        .offset      (req_q.addr[1:0]),
        .split       (split),
        .low         (low_part),
        .high        (mem_r_data),
        .data        (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
`ifdef LSU_MISALIGNED_EN
            cnt_q   <= '0;
            low_q   <= '0;
`else
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
`ifdef LSU_MISALIGNED_EN
            cnt_q   <= cnt_d;
            low_q   <= low_d;
`else
            mis_q   <= mis_d;
`endif
        end
    end

    // Next state and RAM port drive; reset suppresses handshakes and writes at once.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
`ifdef LSU_MISALIGNED_EN
        cnt_d        = cnt_q;
        low_d        = low_q;
`else
        mis_d        = mis_q;
`endif
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_addr     = req_addr;
        mem_w_data   = req_w_data;
        mem_w_width  = req_width;
        mem_w_enable = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                req_ready  = 1'b1;
                resp_valid = (state_q == DONE);
                state_d    = IDLE;
                if (req_valid) begin
                    req_d.is_store    = req_is_store;
                    req_d.addr        = req_addr;
                    req_d.w_data      = req_w_data;
                    req_d.width       = req_width;
                    req_d.is_unsigned = req_unsigned;
`ifdef LSU_MISALIGNED_EN
                    mem_w_enable = req_is_store;
                    if (!cross_in) begin
                        state_d = DONE;
                    end else if (req_is_store) begin
                        mem_w_width = WIDTH_BYTE;
                        cnt_d       = 2'd1;
                        state_d     = STORE_SPLIT;
                    end else begin
                        state_d = LOAD_SPLIT;
                    end
`else
                    mis_d        = cross_in;
                    mem_w_enable = req_is_store && !cross_in;
                    state_d      = DONE;
`endif
                end
            end
`ifdef LSU_MISALIGNED_EN
            LOAD_SPLIT: begin
                mem_addr = {req_q.addr[XLEN-1:2], 2'b00} + XLEN'(4);
                low_d    = mem_r_data;
                state_d  = DONE;
            end
            STORE_SPLIT: begin
                mem_addr     = req_q.addr + XLEN'(cnt_q);
                mem_w_data   = req_q.w_data >> {cnt_q, 3'b000};
                mem_w_width  = WIDTH_BYTE;
                mem_w_enable = 1'b1;
                if ({1'b0, cnt_q} == width_bytes(req_q.width) - 3'd1) begin
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (reset) begin
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            mem_w_enable = 1'b0;
        end
    end

    always_comb begin
        resp_r_data = '0;
        if (!reset && (state_q == DONE) && !req_q.is_store && !resp_misaligned) begin
            resp_r_data = load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM, byte-level reference model and
// scoreboard, directed literal cases and randomized traffic. Honors LSU_MISALIGNED_EN.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_w_data;
    mem_width_t  req_width;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_r_data;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    mem_width_t  mem_w_width;
    logic        mem_w_enable;
    logic [31:0] mem_r_data;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_w_data(req_w_data), .req_width(req_width),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_r_data(resp_r_data), .resp_misaligned(resp_misaligned),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_width(mem_w_width),
        .mem_w_enable(mem_w_enable), .mem_r_data(mem_r_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int w_count  = 0;
    int exp_writes = 0;
    bit run_cmp  = 1'b0;

    logic [7:0] ram     [16];
    logic [7:0] exp_mem [16];

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        mis;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bsize(input mem_width_t w);
        return (w == WIDTH_BYTE) ? 1 : (w == WIDTH_HALFWORD) ? 2 : 4;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // RAM: byte-enabled writes confined to one word; reads return the word shifted by offset.
    always @(posedge clock) begin
        logic [31:0] rd;
        logic [3:0]  a;
        int          sz;
        a  = mem_addr[3:0];
        sz = bsize(mem_w_width);
        if (mem_w_enable) begin
            w_count++;
            chk("ram_write_in_word", 32'(int'(a[1:0]) + sz <= 4), 32'd1);
            for (int k = 0; k < 4; k++)
                if (k < sz) ram[4'(int'(a) + k)] <= mem_w_data[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) rd[8*k +: 8] = ram[{a[3:2], 2'(k)}];
        mem_r_data <= rd >> {a[1:0], 3'b000};
    end

    // Reference behaviour of one accepted request, applied to the byte-level model.
    task automatic model(input bit st, input logic [31:0] a, input logic [31:0] wd,
                         input mem_width_t w, input bit uns, input int acc);
        exp_t        e;
        int          sz;
        int          off;
        bit          cr;
        int          lat;
        logic [31:0] v;
        sz  = bsize(w);
        off = int'(a[1:0]);
        cr  = (off + sz) > 4;
        v   = '0;
        e.mis = MIS_EN ? 1'b0 : cr;
        if (!cr || !MIS_EN) lat = 1;
        else lat = st ? sz : 2;
        if (!e.mis) begin
            if (st) begin
                for (int k = 0; k < sz; k++) exp_mem[4'(int'(a) + k)] = wd[8*k +: 8];
                exp_writes += cr ? sz : 1;
            end else begin
                for (int k = 0; k < sz; k++) v = v | (32'(exp_mem[4'(int'(a) + k)]) << (8*k));
                if (!uns && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            end
        end
        e.data = st ? 32'd0 : v;
        e.due  = acc + lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit st, input logic [31:0] a, input logic [31:0] wd,
                         input mem_width_t w, input bit uns, output int acc);
        @(negedge clock);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_w_data   = wd;
        req_width    = w;
        req_unsigned = uns;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        model(st, a, wd, w, uns, acc);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic lit_req(input string name, input bit st, input logic [31:0] a,
                           input logic [31:0] wd, input mem_width_t w, input bit uns,
                           input logic [31:0] exp_data, input bit exp_mis, input int exp_lat);
        int acc;
        int lat;
        issue(st, a, wd, w, uns, acc);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 10);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, resp_r_data, exp_data);
        chk({name, "_misaligned"}, 32'(resp_misaligned), 32'(exp_mis));
    endtask

    // Scoreboard: every non-reset cycle, resp_valid must match the model's schedule.
    always @(negedge clock) begin
        bit due;
        if (!reset && run_cmp) begin
            due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("resp_valid", 32'(resp_valid), 32'(due));
            if (due && resp_valid) begin
                chk("resp_r_data", resp_r_data, exp_q[0].data);
                chk("resp_misaligned", 32'(resp_misaligned), 32'(exp_q[0].mis));
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        end
    end

    function automatic logic [31:0] ram_word(input int idx);
        return {ram[4*idx+3], ram[4*idx+2], ram[4*idx+1], ram[4*idx]};
    endfunction

    initial begin
        int          acc;
        logic [7:0]  snap [16];
        logic [31:0] init_words [4];
        int          snap_writes;

        init_words[0] = 32'h4433_2211;
        init_words[1] = 32'h8877_6655;
        init_words[2] = 32'hCCBB_AA99;
        init_words[3] = 32'h00FF_EEDD;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = init_words[i/4][8*(i%4) +: 8];
            exp_mem[i] = ram[i];
        end

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_w_data   = '0;
        req_width    = WIDTH_WORD;
        req_unsigned = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_r_data", resp_r_data, 32'd0);
        chk("reset_resp_misaligned", 32'(resp_misaligned), 32'd0);
        chk("reset_mem_w_enable", 32'(mem_w_enable), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        run_cmp = 1'b1;

        lit_req("lh_0x6", 1'b0, 32'h6, 32'h0, WIDTH_HALFWORD, 1'b0, 32'hFFFF_8877, 1'b0, 1);
        lit_req("lbu_0x3", 1'b0, 32'h3, 32'h0, WIDTH_BYTE, 1'b1, 32'h0000_0044, 1'b0, 1);
        lit_req("lw_0x2", 1'b0, 32'h2, 32'h0, WIDTH_WORD, 1'b0,
                MIS_EN ? 32'h6655_4433 : 32'h0, !MIS_EN, MIS_EN ? 2 : 1);
        lit_req("lhu_0x3", 1'b0, 32'h3, 32'h0, WIDTH_HALFWORD, 1'b1,
                MIS_EN ? 32'h0000_5544 : 32'h0, !MIS_EN, MIS_EN ? 2 : 1);
        lit_req("sw_0x3", 1'b1, 32'h3, 32'hDEAD_BEEF, WIDTH_WORD, 1'b0,
                32'h0, !MIS_EN, MIS_EN ? 4 : 1);
        chk("word0_after_sw", ram_word(0), MIS_EN ? 32'hEF33_2211 : 32'h4433_2211);
        chk("word1_after_sw", ram_word(1), MIS_EN ? 32'h88DE_ADBE : 32'h8877_6655);
        lit_req("sw_0x2", 1'b1, 32'h2, 32'hDEAD_BEEF, WIDTH_WORD, 1'b0,
                32'h0, !MIS_EN, MIS_EN ? 4 : 1);
        lit_req("lw_0x0", 1'b0, 32'h0, 32'h0, WIDTH_WORD, 1'b0,
                MIS_EN ? 32'hBEEF_2211 : 32'h4433_2211, 1'b0, 1);

        // Store aborted by reset one cycle after acceptance: only its first write lands.
        for (int i = 0; i < 16; i++) snap[i] = exp_mem[i];
        snap_writes = exp_writes;
        issue(1'b1, 32'h1, 32'hDEAD_BEEF, WIDTH_WORD, 1'b0, acc);
        #1 reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_mem[i] = snap[i];
        exp_writes = snap_writes;
        if (MIS_EN) begin
            exp_mem[1] = 8'hEF;
            exp_writes++;
        end
        @(negedge clock);
        chk("abort_mem_w_enable", 32'(mem_w_enable), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_byte1", 32'(ram[1]), MIS_EN ? 32'hEF : 32'h22);
        chk("abort_byte2", 32'(ram[2]), MIS_EN ? 32'hEF : 32'h33);

        for (int n = 0; n < 300; n++) begin
            mem_width_t w;
            w = mem_width_t'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 11)), $urandom, w,
                  1'($urandom_range(0, 1)), acc);
            idle(int'($urandom_range(0, 2)));
        end

        idle(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(w_count), 32'(exp_writes));
        for (int i = 0; i < 16; i++) chk($sformatf("ram_byte_%0d", i), 32'(ram[i]), 32'(exp_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
